i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDR7, default 7'h50, 7-bit I2C target address matched against the address byte.
REQ-002 SHALL have parameter RESET_VALUE, default 32'h00000000, reset contents of reg[3:0]; reg[n] = RESET_VALUE[8n+7:8n].
REQ-003 SHALL have port clk, input, 1, system clock; all logic in this single clock domain.
REQ-004 SHALL have port nreset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port scl_in, input, 1, raw SCL line level (asynchronous).
REQ-006 SHALL have port sda_in, input, 1, raw SDA line level (asynchronous).
REQ-007 SHALL have port sda_oe, output, 1; 1 = pull SDA low, 0 = release (open-drain).
REQ-008 SHALL have port regs, output, 32, {reg3,reg2,reg1,reg0}.
REQ-009 SHALL have port wr_strobe, output, 1, one-clk pulse per register byte written from I2C.
REQ-010 SHALL have port wr_index, output, 2, index of the register written, valid with wr_strobe.
REQ-011 SHALL have port busy, output, 1, high from an addressed START to STOP/abort.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-FF synchronizers; edges detected on synchronized values (detection latency 3 clk); clk SHALL be >= 16x SCL frequency.
REQ-013 SHALL detect START as SDA falling while SCL high, STOP as SDA rising while SCL high, in any state.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
REQ-015 START (incl. repeated START) SHALL go to ADDR from any state, clear bit counter, release sda_oe; STOP SHALL go to IDLE and release sda_oe.
REQ-016 Data bits SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on SCL falling edge.
REQ-017 ADDR: after 8 bits, if bits[7:1]==ADDR7 go to ADDR_ACK (sda_oe=1 from next SCL fall to following SCL fall), else go to WAIT with sda_oe=0.
REQ-018 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA.
REQ-019 PTR: first write byte is the pointer; ptr = byte[1:0], bits[7:2] ignored; ACKed; then WDATA.
REQ-020 WDATA: each 8th bit SHALL update reg[ptr], pulse wr_strobe with wr_index=ptr one clk after the 8th rising edge is detected, ACK, and increment ptr modulo 4 (3 -> 0 wrap).
REQ-021 RDATA: on the SCL fall ending the ACK, SHALL drive bit7 of reg[ptr] (sda_oe = ~bit), subsequent bits on each SCL fall; after 8 bits release SDA, sample controller ACK on rising edge (RDATA_ACK), increment ptr modulo 4.
REQ-022 RDATA_ACK: SDA low (ACK) -> RDATA next byte; SDA high (NACK) -> WAIT, sda_oe=0.
REQ-023 WAIT SHALL ignore bus activity until START or STOP.
REQ-024 ptr SHALL persist across transactions so a write of pointer then repeated-START read reads from that pointer.
REQ-025 busy SHALL be 1 in all states except IDLE and WAIT.
REQ-026 Simultaneous STOP/START detection and SCL edge in same clk: START/STOP SHALL take priority.

Reset
REQ-027 nreset low SHALL asynchronously force: state IDLE, sda_oe=0, wr_strobe=0, wr_index=0, busy=0, ptr=0, bit counter=0, synchronizers to 1, regs=RESET_VALUE.
REQ-028 Reset mid-transaction SHALL abandon it; after release the block SHALL respond only after a new START.

Configuration
REQ-029 Macro I2C_TARGET_GLITCH_FILTER_EN defined: synchronized SCL and SDA SHALL pass a 3-sample majority filter (adds 2 clk latency, rejects pulses <= 1 clk).
REQ-030 Macro I2C_TARGET_GLITCH_FILTER_EN undefined: no filter; synchronizer outputs used directly.

Verification
REQ-031 Write 0xA0, 0x01, 0xAA, 0x55, STOP -> ACK on all 4 bytes; reg1=0xAA, reg2=0x55; wr_strobe pulses with wr_index 1 then 2.
REQ-032 Write 0xA0, 0x03, STOP; then 0xA1, read 3 bytes (ACK, ACK, NACK) -> returns reg3, reg0, reg1 (wrap); SDA released after NACK.
REQ-033 Address byte 0xB0 -> no ACK (sda_oe stays 0), busy=0, regs unchanged.
REQ-034 Write 0xA0, 0x02, repeated START, 0xA1, read 1 byte NACK -> returns reg2.
REQ-035 Assert nreset during 5th bit of WDATA byte -> sda_oe=0, regs=RESET_VALUE, no wr_strobe; next full write succeeds.
REQ-036 With I2C_TARGET_GLITCH_FILTER_EN, inject 1-clk SCL high glitch during WDATA -> no extra bit counted; byte written correctly.

Source files
------------

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
//   I2C target exposing four 8-bit registers over a single-clock design.
//   The first byte of a write transfer sets the register pointer. Later write
//   bytes go to reg[ptr]. Read transfers return reg[ptr] onward. After every
//   byte the pointer increments modulo 4. The pointer is kept between
//   transfers, so a pointer write followed by a repeated START and a read
//   returns data from that pointer.
//
// Parameters
//   ADDR7        7-bit bus address this target answers to.
//   RESET_VALUE  reset contents {reg3,reg2,reg1,reg0}.
//
// Ports
//   clk        system clock; must run at 16x SCL or faster.
//   nreset     asynchronous active-low reset.
//   scl_in     raw SCL level; asynchronous to clk.
//   sda_in     raw SDA level; asynchronous to clk.
//   sda_oe     1 = pull SDA low, 0 = release (open-drain).
//   regs       {reg3,reg2,reg1,reg0}.
//   wr_strobe  one-clk pulse for each register byte written from the bus.
//   wr_index   index of the written register; valid with wr_strobe.
//   busy       high while the target takes part in a transfer.
//
// Build option
//   I2C_TARGET_GLITCH_FILTER_EN: when defined, the synchronized SCL and SDA
//   go through a 3-sample majority filter. The filter adds 2 clk of latency
//   and rejects pulses of 1 clk or less.
// -----------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0]  ADDR7       = 7'h50,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] regs,
  output logic        wr_strobe,
  output logic [1:0]  wr_index,
  output logic        busy
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT      = 4'd9;

  // Synchronizers and bus-level edge detection
  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  // Protocol state
  logic [3:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [1:0]  r_ptr;
  logic        r_rw;
  logic        r_ack_ph;
  logic        r_sda_oe;
  logic [31:0] r_regs;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_index;
  logic        r_busy;

  // Next-state values
  logic [3:0]  w_state_nxt;
  logic [2:0]  w_cnt_nxt;
  logic [7:0]  w_shift_nxt;
  logic [1:0]  w_ptr_nxt;
  logic        w_rw_nxt;
  logic        w_ack_ph_nxt;
  logic        w_oe_nxt;
  logic [31:0] w_regs_nxt;
  logic        w_wr_stb_nxt;
  logic [1:0]  w_wr_idx_nxt;
  logic        w_busy_nxt;

  logic [7:0]  w_byte;
  logic [7:0]  w_rd_byte;
  logic        w_tx_bit;

  // Two-flop synchronizers; idle-high so reset never looks like bus activity
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist, r_sda_hist;

  function automatic logic maj3(input logic [2:0] v);
    maj3 = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Three-sample history feeding the majority vote
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_s2};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_s2};
    end
  end

  assign w_scl = maj3(r_scl_hist);
  assign w_sda = maj3(r_sda_hist);
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  // Previous line levels used for edge and START/STOP detection
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // An SDA transition while SCL stays high is a bus condition, not data
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_regs[{r_ptr, 3'b000} +: 8];
  // During a read r_shift is loaded once; the bit counter picks the bit to send
  assign w_tx_bit  = r_shift[3'd7 - r_bit_cnt];

  // Next-state decode; START/STOP override any SCL edge in the same clk
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_ack_ph_nxt = r_ack_ph;
    w_oe_nxt     = r_sda_oe;
    w_regs_nxt   = r_regs;
    w_wr_stb_nxt = 1'b0;
    w_wr_idx_nxt = r_wr_index;

    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 3'd0;
      w_oe_nxt     = 1'b0;
      w_ack_ph_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = 3'd0;
      w_oe_nxt     = 1'b0;
      w_ack_ph_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_WAIT: begin
          w_state_nxt = ST_WAIT;
        end
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_byte[7:1] == ADDR7) begin
                w_state_nxt = ST_ADDR_ACK;
                w_rw_nxt    = w_byte[0];
              end else begin
                w_state_nxt = ST_WAIT;
                w_oe_nxt    = 1'b0;
              end
            end else begin
              w_state_nxt = ST_ADDR;
            end
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
        ST_PTR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ptr_nxt   = w_byte[1:0];
              w_state_nxt = ST_PTR_ACK;
            end else begin
              w_state_nxt = ST_PTR;
            end
          end else begin
            w_state_nxt = ST_PTR;
          end
        end
        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_regs_nxt[{r_ptr, 3'b000} +: 8] = w_byte;
              w_wr_stb_nxt = 1'b1;
              w_wr_idx_nxt = r_ptr;
              w_ptr_nxt    = r_ptr + 2'd1;
              w_state_nxt  = ST_WDATA_ACK;
            end else begin
              w_state_nxt = ST_WDATA;
            end
          end else begin
            w_state_nxt = ST_WDATA;
          end
        end
        // First SCL fall starts the ACK bit; second fall ends it
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_ph) begin
              w_oe_nxt     = 1'b1;
              w_ack_ph_nxt = 1'b1;
            end else begin
              w_ack_ph_nxt = 1'b0;
              w_oe_nxt     = 1'b0;
              w_cnt_nxt    = 3'd0;
              if ((r_state == ST_ADDR_ACK) && r_rw) begin
                // Read: the fall that ends the ACK also presents data bit 7
                w_state_nxt = ST_RDATA;
                w_shift_nxt = w_rd_byte;
                w_oe_nxt    = ~w_rd_byte[7];
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = ST_PTR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt  = ST_RDATA_ACK;
              w_ptr_nxt    = r_ptr + 2'd1;
              w_ack_ph_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_RDATA;
            end
          end else if (w_scl_fall) begin
            w_oe_nxt = ~w_tx_bit;
          end else begin
            w_state_nxt = ST_RDATA;
          end
        end
        // r_ack_ph here means the controller ACKed and another byte follows
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (!r_ack_ph) begin
              if (!w_sda) begin
                w_ack_ph_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_WAIT;
                w_oe_nxt    = 1'b0;
              end
            end else begin
              w_state_nxt = ST_RDATA_ACK;
            end
          end else if (w_scl_fall) begin
            if (r_ack_ph) begin
              w_state_nxt  = ST_RDATA;
              w_ack_ph_nxt = 1'b0;
              w_cnt_nxt    = 3'd0;
              w_shift_nxt  = w_rd_byte;
              w_oe_nxt     = ~w_rd_byte[7];
            end else begin
              w_oe_nxt = 1'b0;
            end
          end else begin
            w_state_nxt = ST_RDATA_ACK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_oe_nxt    = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_WAIT);
  end

  // Protocol and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_ptr       <= 2'd0;
      r_rw        <= 1'b0;
      r_ack_ph    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_regs      <= RESET_VALUE;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_ph    <= w_ack_ph_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_regs      <= w_regs_nxt;
      r_wr_strobe <= w_wr_stb_nxt;
      r_wr_index  <= w_wr_idx_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign regs      = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign wr_index  = r_wr_index;
  assign busy      = r_busy;

endmodule
